// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C configuration sequencer and the I2C master
// controller it feeds: device address, delay-entry marker, table entry layout and FSM states.
package i2c_pkg;

    localparam logic [6:0]  I2C_DEV_ADDR   = 7'h3C;
    localparam logic [15:0] I2C_DELAY_MARK = 16'hFFFF;

    typedef struct packed {
        logic [15:0] addr;
        logic [7:0]  data;
    } cfg_entry_t;

    typedef enum logic [2:0] {
        ST_PWR_WAIT = 3'd0,
        ST_LOAD     = 3'd1,
        ST_ISSUE    = 3'd2,
        ST_BUSY     = 3'd3,
        ST_GAP      = 3'd4,
        ST_DELAY    = 3'd5,
        ST_DONE     = 3'd6,
        ST_ERROR    = 3'd7
    } cfg_state_t;

endpackage

// File: rtl/i2c_cfg_rom.sv
// Sensor configuration table, one {register address, data} word per index.
// Only this file changes when the sequencer is retargeted to another sensor.
module i2c_cfg_rom
    import i2c_pkg::*;
#(
    parameter logic [7:0] REG_NUM = 8'd4
) (
    input  logic [7:0]  idx,
    output logic [23:0] cfg_word
);

    always_comb begin
        cfg_word = 24'h0;
        if (idx < REG_NUM) begin
            case (idx)
                8'd0:    cfg_word = {16'h3008, 8'h82};      // soft reset
                8'd1:    cfg_word = {I2C_DELAY_MARK, 8'h02}; // wait 2 units
                8'd2:    cfg_word = {16'h3103, 8'h03};      // clock source select
                8'd3:    cfg_word = {16'h3017, 8'hFF};      // pad output enable
                default: cfg_word = 24'h0;
            endcase
        end
    end

endmodule

// File: rtl/i2c_cfg_seq.sv
// Register-initialisation sequencer: after a power-on wait it turns each table
// entry into one I2C write (or a timed delay) and reports done / timeout error.
module i2c_cfg_seq
    import i2c_pkg::*;
#(
    parameter logic [7:0]  REG_NUM    = 8'd4,
    parameter logic [15:0] POWER_WAIT = 16'd5000,
    parameter logic [7:0]  GAP_CYC    = 8'd8,
    parameter logic [15:0] TIMEOUT    = 16'd2000,
    parameter logic [15:0] DELAY_MARK = I2C_DELAY_MARK,
    parameter logic [15:0] DELAY_UNIT = 16'd250,
    parameter logic        ADDR_16B   = 1'b1
) (
    input  logic        sys_clk,
    input  logic        sys_rst,
    input  logic        cfg_restart,
    input  logic        i2c_end,
    output logic        i2c_start,
    output logic        wr_en,
    output logic        rd_en,
    output logic        addr_num,
    output logic [15:0] byte_addr,
    output logic [7:0]  wr_data,
    output logic [7:0]  cfg_idx,
    output logic        cfg_done,
    output logic        cfg_err
);

    // Terminal counts; a zero-length wait still occupies one cycle.
    localparam logic [23:0] PWR_LAST = (POWER_WAIT == 16'd0) ? 24'd0 : 24'(POWER_WAIT - 16'd1);
    localparam logic [23:0] GAP_LAST = (GAP_CYC == 8'd0)     ? 24'd0 : 24'(GAP_CYC - 8'd1);
    localparam logic [23:0] TO_LAST  = (TIMEOUT == 16'd0)    ? 24'd0 : 24'(TIMEOUT - 16'd1);

    cfg_state_t  r_state;
    cfg_state_t  w_next_state;
    logic [23:0] r_cnt;
    logic [7:0]  r_idx;
    logic [15:0] r_byte_addr;
    logic [7:0]  r_wr_data;
    logic        r_i2c_start;
    logic        r_wr_en;
    logic        r_done;
    logic        r_err;

    logic [23:0] w_cfg_word;
    cfg_entry_t  w_entry;
    logic [23:0] w_delay_len;
    logic [23:0] w_delay_last;
    logic        w_last;
    logic        w_step;

    i2c_cfg_rom #(
        .REG_NUM (REG_NUM)
    ) u_rom (
        .idx      (r_idx),
        .cfg_word (w_cfg_word)
    );

    assign w_entry      = w_cfg_word;
    assign w_delay_len  = 24'(r_wr_data) * 24'(DELAY_UNIT);
    assign w_delay_last = (w_delay_len == 24'd0) ? 24'd0 : w_delay_len - 24'd1;
    assign w_last       = (r_idx == REG_NUM - 8'd1);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        w_next_state = r_state;
        w_step       = 1'b0;
        case (r_state)
            ST_PWR_WAIT: if (r_cnt == PWR_LAST) w_next_state = (REG_NUM == 8'd0) ? ST_DONE : ST_LOAD;
            ST_LOAD:     w_next_state = (w_entry.addr == DELAY_MARK) ? ST_DELAY : ST_ISSUE;
            ST_ISSUE:    w_next_state = ST_BUSY;
            ST_BUSY: begin
                // i2c_end takes priority over a simultaneous timeout
                if (i2c_end)                w_next_state = ST_GAP;
                else if (r_cnt == TO_LAST)  w_next_state = ST_ERROR;
            end
            ST_GAP:      w_step = (r_cnt == GAP_LAST);
            ST_DELAY:    w_step = (r_cnt == w_delay_last);
            ST_DONE,
            ST_ERROR:    if (cfg_restart) w_next_state = ST_LOAD;
            default:     w_next_state = ST_PWR_WAIT;
        endcase
        if (w_step) w_next_state = w_last ? ST_DONE : ST_LOAD;
    end

    // NOTE: state and outputs use non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            r_state     <= ST_PWR_WAIT;
            r_cnt       <= 24'd0;
            r_idx       <= 8'd0;
            r_byte_addr <= 16'h0000;
            r_wr_data   <= 8'h00;
            r_i2c_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_next_state;

            // The timeout window spans ISSUE and BUSY, so the count carries across that step.
            if (r_state == ST_DONE || r_state == ST_ERROR)
                r_cnt <= 24'd0;
            else if (w_next_state != r_state && r_state != ST_ISSUE)
                r_cnt <= 24'd0;
            else
                r_cnt <= r_cnt + 24'd1;

            if (r_state == ST_LOAD) begin
                r_byte_addr <= w_entry.addr;
                r_wr_data   <= w_entry.data;
            end

            if ((r_state == ST_DONE || r_state == ST_ERROR) && cfg_restart)
                r_idx <= 8'd0;
            else if (w_step && !w_last)
                r_idx <= r_idx + 8'd1;

            // Outputs follow the state being entered, so they are aligned with it.
            r_i2c_start <= (w_next_state == ST_ISSUE);
            r_wr_en     <= (w_next_state == ST_ISSUE) || (w_next_state == ST_BUSY);
            r_done      <= (w_next_state == ST_DONE);
            r_err       <= (w_next_state == ST_ERROR);
        end
    end

    assign i2c_start = r_i2c_start;
    assign wr_en     = r_wr_en;
    assign rd_en     = 1'b0;
    assign addr_num  = ADDR_16B;
    assign byte_addr = r_byte_addr;
    assign wr_data   = r_wr_data;
    assign cfg_idx   = r_idx;
    assign cfg_done  = r_done;
    assign cfg_err   = r_err;

endmodule
